// File: rtl/mips_control_unit.sv
// Main decoder: maps the 6-bit MIPS opcode to registered datapath control signals.
// Latency: 1 cycle (opcode sampled at edge N drives outputs after edge N); no comb path opcode->outputs.
// Backpressure: stall holds every output register; flush loads an all-zero NOP and overrides stall.
module mips_control_unit #(
    parameter int OPCODE_W = 6,
    parameter int ALUOP_W  = 3
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [OPCODE_W-1:0] opcode,
    input  logic                stall,
    input  logic                flush,
    output logic                reg_dst,
    output logic                alu_src,
    output logic                mem_to_reg,
    output logic                reg_write,
    output logic                mem_read,
    output logic                mem_write,
    output logic                branch,
    output logic [ALUOP_W-1:0]  alu_op,
    output logic                illegal_op
);

    // Supported opcodes (instruction bits [31:26])
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_SLTI  = 6'b000001;
    localparam logic [5:0] OP_LW    = 6'b000100;
    localparam logic [5:0] OP_SW    = 6'b000101;
    localparam logic [5:0] OP_BEQ   = 6'b000110;
    localparam logic [5:0] OP_ADDI  = 6'b000111;

    // ALU operation classes; codes 100-111 are reserved and never produced
    localparam logic [ALUOP_W-1:0] ALU_ADD   = ALUOP_W'(3'b000);
    localparam logic [ALUOP_W-1:0] ALU_SUB   = ALUOP_W'(3'b001);
    localparam logic [ALUOP_W-1:0] ALU_RTYPE = ALUOP_W'(3'b010);
    localparam logic [ALUOP_W-1:0] ALU_SLT   = ALUOP_W'(3'b011);

    typedef struct packed {
        logic               reg_dst;
        logic               alu_src;
        logic               mem_to_reg;
        logic               reg_write;
        logic               mem_read;
        logic               mem_write;
        logic               branch;
        logic [ALUOP_W-1:0] alu_op;
        logic               illegal_op;
    } ctrl_t;

    localparam ctrl_t CTRL_NOP = '0;

    ctrl_t w_dec;
    ctrl_t r_ctrl;

    // Combinational opcode decode; unlisted (or unknown) opcodes fall to the illegal default
    always_comb begin
        w_dec            = CTRL_NOP;
        w_dec.illegal_op = 1'b1;
        case (opcode[5:0])
            OP_RTYPE: begin
                w_dec.illegal_op = 1'b0;
                w_dec.reg_dst    = 1'b1;
                w_dec.reg_write  = 1'b1;
                w_dec.alu_op     = ALU_RTYPE;
            end
            OP_LW: begin
                w_dec.illegal_op = 1'b0;
                w_dec.alu_src    = 1'b1;
                w_dec.mem_to_reg = 1'b1;
                w_dec.reg_write  = 1'b1;
                w_dec.mem_read   = 1'b1;
                w_dec.alu_op     = ALU_ADD;
            end
            OP_SW: begin
                w_dec.illegal_op = 1'b0;
                w_dec.alu_src    = 1'b1;
                w_dec.mem_write  = 1'b1;
                w_dec.alu_op     = ALU_ADD;
            end
            OP_ADDI: begin
                w_dec.illegal_op = 1'b0;
                w_dec.alu_src    = 1'b1;
                w_dec.reg_write  = 1'b1;
                w_dec.alu_op     = ALU_ADD;
            end
            OP_BEQ: begin
                w_dec.illegal_op = 1'b0;
                w_dec.branch     = 1'b1;
                w_dec.alu_op     = ALU_SUB;
            end
            OP_SLTI: begin
                w_dec.illegal_op = 1'b0;
                w_dec.alu_src    = 1'b1;
                w_dec.reg_write  = 1'b1;
                w_dec.alu_op     = ALU_SLT;
            end
            default: begin
                w_dec            = CTRL_NOP;
                w_dec.illegal_op = 1'b1;
            end
        endcase
    end

    // Output register: reset > flush > stall > decode
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ctrl <= CTRL_NOP;
        end else if (flush) begin
            r_ctrl <= CTRL_NOP;
        end else if (!stall) begin
            r_ctrl <= w_dec;
        end
    end

    assign reg_dst    = r_ctrl.reg_dst;
    assign alu_src    = r_ctrl.alu_src;
    assign mem_to_reg = r_ctrl.mem_to_reg;
    assign reg_write  = r_ctrl.reg_write;
    assign mem_read   = r_ctrl.mem_read;
    assign mem_write  = r_ctrl.mem_write;
    assign branch     = r_ctrl.branch;
    assign alu_op     = r_ctrl.alu_op;
    assign illegal_op = r_ctrl.illegal_op;

endmodule

// File: tb/tb_mips_control_unit.sv
// Testbench for mips_control_unit: directed vector table, reset/stall/flush sequences, random run.
// Outputs are sampled 1 time unit after the rising edge; inputs change on the falling edge.
// Result vector order: reg_dst alu_src mem_to_reg reg_write mem_read mem_write branch alu_op[2:0] illegal_op.
module tb_mips_control_unit;

    logic       clk;
    logic       rst_n;
    logic [5:0] opcode;
    logic       stall;
    logic       flush;
    logic       reg_dst, alu_src, mem_to_reg, reg_write, mem_read, mem_write, branch, illegal_op;
    logic [2:0] alu_op;

    int checks = 0;
    int errors = 0;

    mips_control_unit #(.OPCODE_W(6), .ALUOP_W(3)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .opcode     (opcode),
        .stall      (stall),
        .flush      (flush),
        .reg_dst    (reg_dst),
        .alu_src    (alu_src),
        .mem_to_reg (mem_to_reg),
        .reg_write  (reg_write),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .branch     (branch),
        .alu_op     (alu_op),
        .illegal_op (illegal_op)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [10:0] got;
    assign got = {reg_dst, alu_src, mem_to_reg, reg_write, mem_read, mem_write, branch, alu_op, illegal_op};

    // Hand-computed expected words from the decode table
    localparam logic [10:0] E_NOP  = 11'b0000000_000_0;
    localparam logic [10:0] E_R    = 11'b1001000_010_0;
    localparam logic [10:0] E_LW   = 11'b0111100_000_0;
    localparam logic [10:0] E_SW   = 11'b0100010_000_0;
    localparam logic [10:0] E_ADDI = 11'b0101000_000_0;
    localparam logic [10:0] E_BEQ  = 11'b0000001_001_0;
    localparam logic [10:0] E_SLTI = 11'b0101000_011_0;
    localparam logic [10:0] E_ILL  = 11'b0000000_000_1;

    function automatic logic [10:0] ref_decode(input logic [5:0] op);
        case (op)
            6'b000000: return E_R;
            6'b000100: return E_LW;
            6'b000101: return E_SW;
            6'b000111: return E_ADDI;
            6'b000110: return E_BEQ;
            6'b000001: return E_SLTI;
            default:   return E_ILL;
        endcase
    endfunction

    task automatic check(input string name, input logic [10:0] actual, input logic [10:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s: got %b expected %b", name, actual, expected);
        end
    endtask

    task automatic check_bit(input string name, input logic ok);
        checks++;
        if (ok !== 1'b1) begin
            errors++;
            $display("FAIL %s: invariant value %b required 1 (outputs %b)", name, ok, got);
        end
    endtask

    // Apply inputs on the falling edge, then sample just after the next rising edge
    task automatic step(input logic [5:0] op, input logic st, input logic fl);
        @(negedge clk);
        opcode = op;
        stall  = st;
        flush  = fl;
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        string       name;
        logic [5:0]  op;
        logic        st;
        logic        fl;
        logic [10:0] exp;
    } vec_t;

    vec_t vecs[16];

    logic [10:0] model;
    logic [5:0]  rop;
    logic        rst_s, rfl_s;

    initial begin
        vecs[0]  = '{"rtype",        6'b000000, 1'b0, 1'b0, E_R};
        vecs[1]  = '{"lw",           6'b000100, 1'b0, 1'b0, E_LW};
        vecs[2]  = '{"sw",           6'b000101, 1'b0, 1'b0, E_SW};
        vecs[3]  = '{"addi",         6'b000111, 1'b0, 1'b0, E_ADDI};
        vecs[4]  = '{"beq",          6'b000110, 1'b0, 1'b0, E_BEQ};
        vecs[5]  = '{"slti",         6'b000001, 1'b0, 1'b0, E_SLTI};
        vecs[6]  = '{"illegal_3f",   6'b111111, 1'b0, 1'b0, E_ILL};
        vecs[7]  = '{"illegal_02",   6'b000010, 1'b0, 1'b0, E_ILL};
        vecs[8]  = '{"lw_after_ill", 6'b000100, 1'b0, 1'b0, E_LW};
        vecs[9]  = '{"stall_hold1",  6'b000110, 1'b1, 1'b0, E_LW};
        vecs[10] = '{"stall_hold2",  6'b000110, 1'b1, 1'b0, E_LW};
        vecs[11] = '{"stall_hold3",  6'b000110, 1'b1, 1'b0, E_LW};
        vecs[12] = '{"stall_release",6'b000110, 1'b0, 1'b0, E_BEQ};
        vecs[13] = '{"flush_stall",  6'b000111, 1'b1, 1'b1, E_NOP};
        vecs[14] = '{"after_flush",  6'b000111, 1'b0, 1'b0, E_ADDI};
        vecs[15] = '{"flush_only",   6'b000100, 1'b0, 1'b1, E_NOP};

        // Reset state while held low
        rst_n  = 1'b0;
        opcode = 6'b000000;
        stall  = 1'b0;
        flush  = 1'b0;
        #2;
        check("reset_hold", got, E_NOP);

        // Release on a falling edge; first rising edge decodes R-type
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("reset_release_rtype", got, E_R);

        // Asynchronous assertion mid-cycle clears outputs without a clock edge
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("reset_async", got, E_NOP);
        @(negedge clk);
        rst_n = 1'b1;

        // Directed vector table
        for (int i = 0; i < 16; i++) begin
            step(vecs[i].op, vecs[i].st, vecs[i].fl);
            check(vecs[i].name, got, vecs[i].exp);
        end

        // Randomized opcodes, stall and flush against the reference model
        model = got;
        for (int c = 0; c < 1000; c++) begin
            if ($urandom_range(0, 3) == 0) rop = 6'($urandom);
            else begin
                case ($urandom_range(0, 5))
                    0: rop = 6'b000000;
                    1: rop = 6'b000100;
                    2: rop = 6'b000101;
                    3: rop = 6'b000111;
                    4: rop = 6'b000110;
                    default: rop = 6'b000001;
                endcase
            end
            rst_s = ($urandom_range(0, 3) == 0);
            rfl_s = ($urandom_range(0, 9) == 0);
            step(rop, rst_s, rfl_s);
            if (rfl_s)       model = E_NOP;
            else if (!rst_s) model = ref_decode(rop);
            check("random_model", got, model);
            check_bit("inv_rd_wr", !(mem_read && mem_write));
            check_bit("inv_regwrite", !reg_write || (!mem_write && !branch));
            check_bit("inv_onehot", (int'(mem_read) + int'(mem_write) + int'(branch)) <= 1);
            check_bit("inv_aluop_range", alu_op[2] == 1'b0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mips_control_unit.md
Name: mips_control_unit

Overview:
Main decoder of the single-issue MIPS datapath. It maps the 6-bit instruction opcode to the datapath control signals: register-file destination select, ALU operand select, write-back select, register write, memory read/write, branch and a 3-bit ALU operation class. Outputs are registered, one cycle after the opcode, and feed the execute/memory/write-back stages. Stall and flush inputs allow pipeline control.

Parameters:
OPCODE_W, 6, opcode width; fixed at 6, not to be overridden.
ALUOP_W, 3, width of alu_op.

Ports:
clk  input  1  system clock; all state updates on rising edge
rst_n  input  1  asynchronous active-low reset
opcode  input  6  instruction bits [31:26]
stall  input  1  1 = hold all registered outputs unchanged
flush  input  1  1 = load NOP (all controls 0) on next edge
reg_dst  output  1  1 = write rd, 0 = write rt
alu_src  output  1  1 = ALU operand B is sign-extended immediate
mem_to_reg  output  1  1 = write-back data from memory
reg_write  output  1  register-file write enable
mem_read  output  1  data-memory read enable
mem_write  output  1  data-memory write enable
branch  output  1  conditional branch (BEQ)
alu_op  output  3  ALU operation class
illegal_op  output  1  opcode not in the supported set

Behaviour:
- Reset (rst_n=0, asynchronous): all outputs 0 immediately, held while low. Release is synchronous to the next clk edge.
- Latency: the opcode present at rising edge N appears on the outputs after edge N. The decode is combinational into an output register; there is no combinational path from opcode to outputs.
- Priority at each edge: reset > flush > stall > decode.
- Flush: all outputs 0, illegal_op 0. Flush wins over a simultaneous stall.
- Stall (flush=0): registers keep their value; opcode is ignored.
- alu_op encoding:
  - 000 = add (address/ADDI)
  - 001 = subtract (BEQ compare)
  - 010 = R-type, ALU decodes funct
  - 011 = set-less-than
  - 100–111 reserved, never driven
- Decode table, field order reg_dst alu_src mem_to_reg reg_write mem_read mem_write branch alu_op:
  - 000000 R-type: 1 0 0 1 0 0 0 010
  - 000100 LW: 0 1 1 1 1 0 0 000
  - 000101 SW: 0 1 0 0 0 1 0 000
  - 000111 ADDI: 0 1 0 1 0 0 0 000
  - 000110 BEQ: 0 0 0 0 0 0 1 001
  - 000001 SLTI: 0 1 0 1 0 0 0 011
- Don't-care fields (SW reg_dst/mem_to_reg, BEQ reg_dst/mem_to_reg) are driven 0, never X.
- illegal_op = 0 for the six supported opcodes.
- Any other opcode: every control 0, alu_op 000, illegal_op 1. The decoder has no side effects and the next legal opcode decodes normally.
- Invariants, every cycle: mem_read and mem_write never both 1; reg_write=1 implies mem_write=0 and branch=0; at most one of mem_read, mem_write, branch is 1.
- X/Z on opcode when not stalled: the result is treated as illegal (all controls 0, illegal_op 1).

Test Plan:
- Reset: drive rst_n=0 mid-cycle with opcode=000000 → all outputs 0 without waiting for an edge; release, next edge → reg_dst=1, reg_write=1, alu_op=010.
- Sequence 000000, 000100, 000101, 000111, 000110, 000001, one per cycle → outputs match the table one cycle later, e.g. LW gives alu_src=1, mem_to_reg=1, reg_write=1, mem_read=1; BEQ gives branch=1, alu_op=001; SLTI gives alu_op=011; illegal_op=0 throughout.
- Illegal opcodes 111111 and 000010 → all controls 0, alu_op=000, illegal_op=1; next opcode 000100 decodes as LW.
- Stall: latch LW, assert stall and apply 000110 for 3 cycles → LW outputs held; deassert → BEQ outputs after one edge.
- Flush with stall both 1 while opcode=000111 → all outputs 0 next edge; drop both → ADDI outputs (alu_src=1, reg_write=1).
- Randomized opcodes, stall and flush for 1000 cycles → invariants hold and outputs match a reference table model every cycle.
